qcontrol_lanes: RTL and testbench

- Parametrised, multi-lane successor of the single-lane barrier/payment controller.
- N_LANES independent lane FSMs share one clock and reset.
- Each lane sequences: entry detect -> payment verdict -> entry barrier -> exit barrier -> idle.
- Adds payment timeout, timed reject indication, DCE edge qualification and per-lane wrapping pass counters; sits between the lane sensors/payment terminal and the barrier/lamp drivers.

---
 rtl/qcontrol_lanes.sv | 126 ++++++++++++
 tb/tb_qcontrol_lanes.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qcontrol_lanes.sv
// Multi-lane barrier/payment controller: one independent Moore FSM per lane.
// Optional emergency override via QCONTROL_LANES_EMERGENCY_EN (adds EMG input).
module qcontrol_lanes #(
  parameter int unsigned N_LANES       = 2,
  parameter int unsigned PAY_TIMEOUT   = 16,
  parameter int unsigned REJECT_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
`ifdef QCONTROL_LANES_EMERGENCY_EN
  input  logic                     EMG,
`endif
  input  logic [N_LANES-1:0]       DCE,
  input  logic [N_LANES-1:0]       POK,
  input  logic [N_LANES-1:0]       PNOK,
  input  logic [N_LANES-1:0]       DCS,
  output logic [N_LANES-1:0]       Me,
  output logic [N_LANES-1:0]       Ms,
  output logic [N_LANES-1:0]       Lok,
  output logic [N_LANES-1:0]       Lnok,
  output logic [N_LANES*CNT_W-1:0] PassCnt
);

  localparam int unsigned MaxT = (PAY_TIMEOUT > REJECT_CYCLES) ? PAY_TIMEOUT : REJECT_CYCLES;
  localparam int unsigned TW   = $clog2(MaxT + 1);
  localparam logic [TW-1:0] PayLast = TW'(PAY_TIMEOUT - 1);
  localparam logic [TW-1:0] RejLast = TW'(REJECT_CYCLES - 1);

`ifdef QCONTROL_LANES_EMERGENCY_EN
  typedef enum logic [2:0] {
    StIdle, StWaitPay, StPassIn, StPassOut, StReject, StEmergency
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StWaitPay, StPassIn, StPassOut, StReject
  } state_e;
`endif

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dce_q;
    logic              dce_rise;

    assign dce_rise = DCE[i] & ~dce_q;

    always_comb begin
      state_d = state_q;
      timer_d = '0;
      cnt_d   = cnt_q;
      case (state_q)
        StIdle: begin
          if (dce_rise) state_d = StWaitPay;
        end
        StWaitPay: begin
          // Refusal wins over acceptance when the terminal reports both.
          if (PNOK[i]) begin
            state_d = StReject;
          end else if (POK[i]) begin
            state_d = StPassIn;
          end else if (timer_q == PayLast) begin
            state_d = StReject;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        StPassIn: begin
          if (DCS[i]) state_d = StPassOut;
        end
        StPassOut: begin
          if (!DCS[i]) begin
            state_d = StIdle;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        StReject: begin
          if (timer_q == RejLast) state_d = StIdle;
          else                    timer_d = timer_q + TW'(1);
        end
`ifdef QCONTROL_LANES_EMERGENCY_EN
        StEmergency: begin
          state_d = StIdle;
          timer_d = timer_q;
        end
`endif
        default: state_d = StIdle;
      endcase
`ifdef QCONTROL_LANES_EMERGENCY_EN
      if (EMG) begin
        state_d = StEmergency;
        timer_d = timer_q;
        cnt_d   = cnt_q;
      end
`endif
    end

    // dce_q tracks DCE in every state, so leaving emergency sees the parked level.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        state_q <= StIdle;
        timer_q <= '0;
        cnt_q   <= '0;
        dce_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        cnt_q   <= cnt_d;
        dce_q   <= DCE[i];
      end
    end

`ifdef QCONTROL_LANES_EMERGENCY_EN
    assign Me[i] = (state_q == StPassIn)  || (state_q == StEmergency);
    assign Ms[i] = (state_q == StPassOut) || (state_q == StEmergency);
`else
    assign Me[i] = (state_q == StPassIn);
    assign Ms[i] = (state_q == StPassOut);
`endif
    assign Lok[i]  = (state_q == StPassIn) || (state_q == StPassOut);
    assign Lnok[i] = (state_q == StReject);
    assign PassCnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_qcontrol_lanes.sv
// Self-checking bench for qcontrol_lanes: directed steps plus randomized traffic
// compared every cycle against a phase/age based reference model.
module tb_qcontrol_lanes;
  localparam int N     = 2;
  localparam int PT    = 16;
  localparam int RC    = 4;
  localparam int CW    = 8;

  localparam int M_IDLE = 0, M_PAY = 1, M_IN = 2, M_OUT = 3, M_REJ = 4, M_EMG = 5;

  logic          CLK, RST, emg;
  logic [N-1:0]  DCE, POK, PNOK, DCS;
  logic [N-1:0]  Me, Ms, Lok, Lnok;
  logic [N*CW-1:0] PassCnt;

  int mode [N];
  int age  [N];
  int passes [N];
  int total [N];
  logic pdce [N];

  int checks = 0;
  int errors = 0;

  qcontrol_lanes #(
    .N_LANES(N), .PAY_TIMEOUT(PT), .REJECT_CYCLES(RC), .CNT_W(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
`ifdef QCONTROL_LANES_EMERGENCY_EN
    .EMG(emg),
`endif
    .DCE(DCE),
    .POK(POK),
    .PNOK(PNOK),
    .DCS(DCS),
    .Me(Me),
    .Ms(Ms),
    .Lok(Lok),
    .Lnok(Lnok),
    .PassCnt(PassCnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mode[i] = M_IDLE; age[i] = 0; passes[i] = 0; pdce[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (emg) begin
        mode[i] = M_EMG;
      end else begin
        case (mode[i])
          M_IDLE: if (DCE[i] && !pdce[i]) begin mode[i] = M_PAY; age[i] = 0; end
          M_PAY: begin
            age[i]++;
            if (PNOK[i])           begin mode[i] = M_REJ; age[i] = 0; end
            else if (POK[i])       mode[i] = M_IN;
            else if (age[i] == PT) begin mode[i] = M_REJ; age[i] = 0; end
          end
          M_IN:  if (DCS[i]) mode[i] = M_OUT;
          M_OUT: if (!DCS[i]) begin
            mode[i] = M_IDLE;
            passes[i] = (passes[i] + 1) % (1 << CW);
            total[i]++;
          end
          M_REJ: begin
            age[i]++;
            if (age[i] == RC) mode[i] = M_IDLE;
          end
          default: mode[i] = M_IDLE;
        endcase
      end
      pdce[i] = DCE[i];
    end
  endtask

  function automatic logic [63:0] exp_vec();
    logic [N-1:0] me, ms, lok, lnok;
    logic [N*CW-1:0] pc;
    for (int i = 0; i < N; i++) begin
      me[i]   = (mode[i] == M_IN)  || (mode[i] == M_EMG);
      ms[i]   = (mode[i] == M_OUT) || (mode[i] == M_EMG);
      lok[i]  = (mode[i] == M_IN)  || (mode[i] == M_OUT);
      lnok[i] = (mode[i] == M_REJ);
      pc[i*CW +: CW] = CW'(passes[i]);
    end
    return 64'({me, ms, lok, lnok, pc});
  endfunction

  function automatic logic [63:0] act_vec();
    return 64'({Me, Ms, Lok, Lnok, PassCnt});
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (RST) model_step();
    #1;
    check("cycle", act_vec(), exp_vec());
  endtask

  initial begin
    int n;
    int start;
    int cyc;
    for (int i = 0; i < N; i++) total[i] = 0;
    model_reset();
    RST = 1'b0; emg = 1'b0;
    DCE = '0; POK = '0; PNOK = '0; DCS = '0;

    // Reset state
    #3;
    check("reset_outputs", act_vec(), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    tick();

    // Lane 0 full pass
    DCE[0] = 1'b1; tick();
    DCE[0] = 1'b0; tick();
    POK[0] = 1'b1; tick();
    POK[0] = 1'b0;
    check("pass_me_lok", 64'({Me[0], Lok[0], Ms[0]}), 64'b110);
    tick();
    check("pass_hold_open", 64'({Me[0], Lok[0]}), 64'b11);
    DCS[0] = 1'b1; tick();
    check("pass_ms", 64'({Me[0], Ms[0], Lok[0]}), 64'b011);
    tick(); tick();
    DCS[0] = 1'b0; tick();
    check("pass_cnt", 64'(PassCnt[CW-1:0]), 64'd1);
    check("pass_idle", 64'({Me[0], Ms[0], Lok[0], Lnok[0]}), 64'd0);

    // Async reset mid WAIT_PAY on lane 0
    DCE[0] = 1'b1; tick();
    tick();
    #2;
    RST = 1'b0;
    DCE[0] = 1'b0;
    #1;
    check("async_reset", act_vec(), 64'd0);
    model_reset();
    #7;
    RST = 1'b1;
    tick();
    POK[0] = 1'b1; tick();
    POK[0] = 1'b0;
    check("post_reset_idle", 64'(Me[0]), 64'd0);

    // Lane 1 with POK and PNOK together
    DCE[1] = 1'b1; tick();
    POK[1] = 1'b1; PNOK[1] = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      POK[1] = 1'b0; PNOK[1] = 1'b0;
      n += int'(Lnok[1]);
      check("both_me_low", 64'(Me[1]), 64'd0);
    end
    check("both_lnok_len", 64'(n), 64'(RC));
    check("both_cnt", 64'(PassCnt[CW +: CW]), 64'd0);
    DCE[1] = 1'b0;

    // Lane 0 payment timeout with DCE held high
    DCE[0] = 1'b1; tick();
    for (int k = 1; k <= PT; k++) begin
      tick();
      check("timeout_lnok", 64'(Lnok[0]), 64'(k == PT));
    end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n += int'(Lnok[0]);
    end
    check("timeout_lnok_len", 64'(n), 64'(RC - 1));
    POK[0] = 1'b1; tick();
    POK[0] = 1'b0;
    check("timeout_no_retrigger", 64'(Me[0]), 64'd0);
    DCE[0] = 1'b0; tick();

    // Randomized concurrent traffic; lane 0 drives 256 passes to wrap its counter
    start = total[0];
    cyc = 0;
    while ((total[0] - start) < 256 && cyc < 20000) begin
      case (mode[0])
        M_IDLE:  DCE[0] = ~DCE[0];
        M_PAY:   POK[0] = 1'($urandom_range(1));
        M_IN:    DCS[0] = 1'($urandom_range(1));
        M_OUT:   DCS[0] = ($urandom_range(2) == 0);
        default: begin POK[0] = 1'b0; DCS[0] = 1'b0; end
      endcase
      if (mode[0] != M_PAY) POK[0] = 1'b0;
      DCE[1]  = 1'($urandom_range(1));
      POK[1]  = ($urandom_range(3) == 0);
      PNOK[1] = ($urandom_range(7) == 0);
      DCS[1]  = 1'($urandom_range(1));
      tick();
      cyc++;
    end
    check("wrap_reached", 64'((total[0] - start) >= 256), 64'd1);
    check("wrap_cnt0", 64'(PassCnt[CW-1:0]), 64'd0);
    check("lane1_cnt", 64'(PassCnt[CW +: CW]), 64'(passes[1] % (1 << CW)));

`ifdef QCONTROL_LANES_EMERGENCY_EN
    // Drain both lanes to idle, then exercise the emergency override
    DCE = '0; POK = '0; PNOK = '0; DCS = '0;
    cyc = 0;
    while ((mode[0] != M_IDLE || mode[1] != M_IDLE) && cyc < 200) begin
      for (int i = 0; i < N; i++) DCS[i] = (mode[i] == M_IN);
      tick();
      cyc++;
    end
    check("drain_idle", 64'(mode[0] == M_IDLE && mode[1] == M_IDLE), 64'd1);
    DCS = '0;
    DCE = 2'b11; tick();
    POK = 2'b01; tick();
    POK = '0;
    check("pre_emg_me", 64'(Me), 64'b01);
    emg = 1'b1; tick();
    check("emg_me_ms", 64'({Me, Ms, Lok, Lnok}), 64'b11110000);
    DCS = 2'b11; tick();
    DCS = 2'b00; tick();
    check("emg_frozen_cnt", 64'(PassCnt), 64'({CW'(passes[1]), CW'(passes[0])}));
    emg = 1'b0; tick();
    check("emg_release_idle", 64'({Me, Ms, Lok, Lnok}), 64'd0);
    POK = 2'b11; tick();
    POK = '0;
    check("emg_no_spurious_pay", 64'(Me), 64'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
